golden_nonce_uart_tx: RTL and testbench

- Return path of the serial miner link. The host pushes work (midstate, data, starting nonce) into the miner over RxD; this block carries results the other way.
- Queues each golden nonce produced by the hasher core and serialises it to the host on TxD as four 8N1 UART bytes, least-significant byte first.
- Sits in fpgaminer_top between the golden_nonce/valid outputs of the hasher pipeline and the TxD pin.

---
 rtl/miner_link_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 121 ++++++++++++
 rtl/golden_nonce_uart_tx.sv | 147 ++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_link_pkg.sv
// Shared definitions for the serial miner link (host <-> miner UART path).
//   tx_state_t           : byte transmitter states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS       : data bits per 8N1 character
//   NONCE_BYTES          : bytes per golden nonce on the wire
//   DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
package miner_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int NONCE_BYTES          = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 UART character transmitter with a baud counter.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   start_i    : accept data_i this cycle (honoured when ready_o=1)
//   data_i     : byte to send, LSB first
//   ready_o    : transmitter can take a new byte on this edge (idle, or
//                last cycle of a stop bit, which gives gap-free chaining)
//   done_o     : last cycle of the current stop bit
//   idle_o     : FSM is in IDLE
//   txd_o      : registered serial output, idle high
module uart_tx_byte
    import miner_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       idle_o,
    output logic       txd_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d  = '0;
                ready_o = 1'b1;
                if (start_i) begin
                    state_d = START;
                    shift_d = data_i;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    ready_o = 1'b1;
                    done_o  = 1'b1;
                    // Chaining straight into START keeps the bytes of a
                    // nonce contiguous on the wire.
                    if (start_i) begin
                        state_d = START;
                        shift_d = data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is registered from the current state, so txd trails
    // the state by exactly one cycle for every bit alike.
    always_comb begin
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign idle_o = (state_q == IDLE);
    assign txd_o  = txd_q;

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Golden nonce return path: buffers nonces from the hasher in a small FIFO
// and sends each as four 8N1 bytes, least-significant byte first.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   golden_nonce_in     : nonce to report, sampled when golden_nonce_valid=1
//   golden_nonce_valid  : single-cycle push strobe
//   txd                 : UART serial out, idle high
//   busy                : frame on the wire or nonces queued
//   overflow            : sticky, a push was dropped on a full FIFO
//   fifo_count          : queued nonces, excluding the one being sent
module golden_nonce_uart_tx
    import miner_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 golden_nonce_in,
    input  logic                        golden_nonce_valid,
    output logic                        txd,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BYTE_W = $clog2(NONCE_BYTES);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NONCE_BYTES - 1);

    // FIFO storage and pointers
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty, fifo_full;
    logic             push, accept, drop, pop;
    logic [31:0]      head;

    // Byte sequencing for the nonce in flight
    logic              sending_q, sending_d;
    logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic              overflow_q, busy_q;

    // Byte transmitter handshake
    logic       tx_start, tx_ready, tx_done, tx_idle, tx_txd;
    logic [7:0] tx_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign push       = golden_nonce_valid;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign accept     = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    always_comb begin
        pop        = 1'b0;
        tx_start   = 1'b0;
        tx_data    = word_q[7:0];
        sending_d  = sending_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (!sending_q) begin
            if (!fifo_empty && tx_ready) begin
                pop        = 1'b1;
                tx_start   = 1'b1;
                tx_data    = head[7:0];
                sending_d  = 1'b1;
                byte_idx_d = '0;
                word_d     = head >> 8;
            end
        end else if (tx_done) begin
            if (byte_idx_q == BYTE_LAST) begin
                // Going idle here, not chaining, yields the one-cycle gap
                // between consecutive nonces.
                sending_d = 1'b0;
            end else begin
                tx_start   = 1'b1;
                tx_data    = word_q[7:0];
                word_d     = word_q >> 8;
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    // Storage is not reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= golden_nonce_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sending_q  <= 1'b0;
            byte_idx_q <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            sending_q  <= sending_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            // Registered like txd, so busy covers the final stop bit as it
            // actually appears on the line.
            busy_q <= !tx_idle || !fifo_empty;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk    (clk),
        .reset  (reset),
        .start_i(tx_start),
        .data_i (tx_data),
        .ready_o(tx_ready),
        .done_o (tx_done),
        .idle_o (tx_idle),
        .txd_o  (tx_txd)
    );

    assign txd        = tx_txd;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Testbench for golden_nonce_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Stimulus pushes expected bytes into a scoreboard queue; a UART monitor
// decodes txd and compares each received byte against the queue head.
module tb_golden_nonce_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] golden_nonce_in = '0;
    logic        golden_nonce_valid = 1'b0;
    logic        txd, busy, overflow;
    logic [2:0]  fifo_count;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  sb_q [$];
    int          fall_q [$];

    golden_nonce_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .golden_nonce_in   (golden_nonce_in),
        .golden_nonce_valid(golden_nonce_valid),
        .txd               (txd),
        .busy              (busy),
        .overflow          (overflow),
        .fifo_count        (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Push one nonce on the next edge; optionally record its bytes as expected.
    task automatic push_word(input logic [31:0] w, input bit expect_it);
        golden_nonce_in    = w;
        golden_nonce_valid = 1'b1;
        @(posedge clk);
        #1;
        golden_nonce_valid = 1'b0;
        if (expect_it) begin
            for (int b = 0; b < 4; b++) begin
                sb_q.push_back(w[8*b +: 8]);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check({name, "_idle_timeout"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
    endtask

    // UART monitor: samples mid-bit on the falling clock edge.
    initial begin : monitor
        logic [7:0] rx;
        logic       stop_b;
        bit         ok;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) continue;
            if (txd === 1'b0) begin
                fall_q.push_back(cyc);
                ok     = 1'b1;
                rx     = '0;
                stop_b = 1'b0;
                for (int t = 1; t <= 38; t++) begin
                    @(negedge clk);
                    if (reset !== 1'b0) begin
                        ok = 1'b0;
                        break;
                    end
                    if (t >= 6 && t <= 34 && ((t - 6) % 4) == 0) rx[(t - 6) / 4] = txd;
                    if (t == 38) stop_b = txd;
                end
                if (ok) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %02h expected none", rx);
                    end else begin
                        exp = sb_q.pop_front();
                        check("rx_byte", rx, exp);
                        check("rx_stop", stop_b, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0, f, n, low_cnt, fc_max;
        logic [31:0] w6 [6];
        w6[0] = 32'h11223344; w6[1] = 32'h55667788; w6[2] = 32'h99aabbcc;
        w6[3] = 32'hddeeff00; w6[4] = 32'h0badf00d; w6[5] = 32'hcafef00d;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_overflow", overflow, 0);
        check("reset_fifo_count", fifo_count, 0);

        // Idle line
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1 || busy !== 1'b0) low_cnt++;
        end
        check("idle_line_bad_cycles", low_cnt, 0);

        // Single nonce: latency and frame length
        fall_q.delete();
        push_word(32'h1afda099, 1'b1);
        e0 = cyc;
        n = 0;
        while (txd !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_fall_latency", cyc - e0, 2);
        f = cyc;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_busy_drop", cyc - f, 160);
        wait_idle("t1");
        check("t1_byte_count", fall_q.size(), 4);

        // Back-to-back nonces
        fall_q.delete();
        push_word(32'h00000001, 1'b1);
        push_word(32'hFFFFFFFF, 1'b1);
        fc_max = 0;
        n = 0;
        while ((busy !== 1'b0 || sb_q.size() != 0) && n < 1000) begin
            if (int'(fifo_count) > fc_max) fc_max = int'(fifo_count);
            @(posedge clk);
            #1;
            n++;
        end
        check("t2_fifo_count_peak", fc_max, 1);
        wait_idle("t2");
        check("t2_byte_count", fall_q.size(), 8);
        if (fall_q.size() >= 5) begin
            check("t2_byte_spacing", fall_q[1] - fall_q[0], 40);
            check("t2_nonce_spacing", fall_q[4] - fall_q[0], 161);
        end

        // Overflow: sixth push in a row is dropped
        fall_q.delete();
        for (int i = 0; i < 5; i++) push_word(w6[i], 1'b1);
        check("t3_overflow_after_5", overflow, 0);
        push_word(w6[5], 1'b0);
        check("t3_overflow_after_6", overflow, 1);
        check("t3_fifo_count_full", fifo_count, 4);
        wait_idle("t3");
        check("t3_byte_count", fall_q.size(), 20);
        check("t3_overflow_sticky", overflow, 1);
        do_reset();
        check("t3_overflow_cleared", overflow, 0);

        // Push while full with a simultaneous pop
        fall_q.delete();
        push_word(w6[0], 1'b1);
        e0 = cyc;
        for (int i = 1; i < 5; i++) push_word(w6[i], 1'b1);
        n = 0;
        while (cyc < e0 + 161 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_full_before", fifo_count, 4);
        push_word(w6[5], 1'b1);
        check("t4_count_after_push_pop", fifo_count, 4);
        check("t4_overflow", overflow, 0);
        wait_idle("t4");
        check("t4_byte_count", fall_q.size(), 24);
        check("t4_overflow_end", overflow, 0);

        // Reset mid-frame: bit 3 of byte 1, two nonces queued
        fall_q.delete();
        push_word(32'h12345678, 1'b1);
        e0 = cyc;
        push_word(32'h9abcdef0, 1'b1);
        push_word(32'h0f1e2d3c, 1'b1);
        while (cyc < e0 + 59) begin
            @(posedge clk);
            #1;
        end
        check("t5_queued_before", fifo_count, 2);
        check("t5_txd_before_is_data", txd, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_txd_after_reset", txd, 1);
        check("t5_fifo_count_after_reset", fifo_count, 0);
        check("t5_busy_after_reset", busy, 0);
        check("t5_bytes_left", sb_q.size(), 11);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        low_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1 || busy !== 1'b0) low_cnt++;
        end
        check("t5_quiet_after_reset", low_cnt, 0);
        check("t5_byte_count", fall_q.size(), 2);

        check("final_scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
